// File: rtl/fase2_pkg.sv
// rtl/fase2_pkg.sv - shared states, opcodes and select encodings for the Fase 2 multicycle control
package fase2_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - Moore multicycle control unit with memory stall and sticky trap
module unidad_control_multiciclo
  import fase2_pkg::*;
#(
  parameter bit HAS_JUMP = 1'b1,
  parameter bit HAS_ADDI = 1'b1,
  parameter int STATEW   = 4
) (
  input  logic              clkFase,
  input  logic              rstFase,
  input  logic [5:0]        Opcode,
  input  logic              MemReady,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemToReg,
  output logic              IRWrite,
  output logic              RegDst,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        PCSource,
  output logic [1:0]        ALUSrcB,
  output logic [2:0]        ALUOp,
  output logic [STATEW-1:0] State,
  output logic              Illegal
);

  state_t state, state_n;
  // Opcode is only valid in DECODE, so MEMADR relies on this captured lw/sw choice.
  logic   is_store;

  always_ff @(posedge clkFase or posedge rstFase) begin
    if (rstFase) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) is_store <= (Opcode == OP_SW);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (MemReady) state_n = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_n = S_EXEC;
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_BEQ:       state_n = S_BRANCH;
          OP_J:         state_n = HAS_JUMP ? S_JUMP : S_TRAP;
          OP_ADDI:      state_n = HAS_ADDI ? S_ADDIEX : S_TRAP;
          default:      state_n = S_TRAP;
        endcase
      end
      S_MEMADR: state_n = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) state_n = S_MEMWB;
      S_MEMWB:  state_n = S_FETCH;
      S_MEMWR:  if (MemReady) state_n = S_FETCH;
      S_EXEC:   state_n = S_RWB;
      S_RWB:    state_n = S_FETCH;
      S_BRANCH: state_n = S_FETCH;
      S_JUMP:   state_n = S_FETCH;
      S_ADDIEX: state_n = S_ADDIWB;
      S_ADDIWB: state_n = S_FETCH;
      S_TRAP:   state_n = S_TRAP;
      default:  state_n = S_FETCH;
    endcase
  end

  // Reset masks the decoder combinationally so an abort drops enables before the next edge.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALU_ADD;
    Illegal     = 1'b0;
    if (!rstFase) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        S_DECODE: ALUSrcB = SRCB_IMM_SH2;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_FUNCT;
        end
        S_RWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_TRAP:   Illegal  = 1'b1;
        default: ;
      endcase
    end
  end

  assign State = STATEW'(state);

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - randomized plan-based model check of the multicycle control unit
module tb_unidad_control_multiciclo;
  import fase2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mr;
  logic [5:0] op;
  logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_m2r, a_irw, a_rdst, a_rw, a_asa, a_ill;
  logic [1:0] a_pcs, a_asb;
  logic [2:0] a_aop;
  logic [3:0] st;
  logic [17:0] a_vec;

  logic       b_rst, b_mr;
  logic [5:0] b_op;
  logic       b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_m2r, b_irw, b_rdst, b_rw, b_asa, b_ill;
  logic [1:0] b_pcs, b_asb;
  logic [2:0] b_aop;
  logic [3:0] b_st;
  logic [17:0] b_vec;

  unidad_control_multiciclo dut_a (
    .clkFase(clk), .rstFase(rst), .Opcode(op), .MemReady(mr),
    .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
    .MemWrite(a_mwr), .MemToReg(a_m2r), .IRWrite(a_irw), .RegDst(a_rdst),
    .RegWrite(a_rw), .ALUSrcA(a_asa), .PCSource(a_pcs), .ALUSrcB(a_asb),
    .ALUOp(a_aop), .State(st), .Illegal(a_ill)
  );

  unidad_control_multiciclo #(.HAS_JUMP(1'b0), .HAS_ADDI(1'b0), .STATEW(4)) dut_b (
    .clkFase(clk), .rstFase(b_rst), .Opcode(b_op), .MemReady(b_mr),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
    .MemWrite(b_mwr), .MemToReg(b_m2r), .IRWrite(b_irw), .RegDst(b_rdst),
    .RegWrite(b_rw), .ALUSrcA(b_asa), .PCSource(b_pcs), .ALUSrcB(b_asb),
    .ALUOp(b_aop), .State(b_st), .Illegal(b_ill)
  );

  assign a_vec = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_m2r, a_irw, a_rdst, a_rw, a_asa,
                  a_pcs, a_asb, a_aop, a_ill};
  assign b_vec = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_m2r, b_irw, b_rdst, b_rw, b_asa,
                  b_pcs, b_asb, b_aop, b_ill};

  int passed = 0;
  int total  = 0;

  int          mq[$];
  int          hist[$];
  logic [5:0]  cur_op;
  int          cycles, nmw, nrw, nm2r, m2r_bad, stall_left;
  logic [17:0] cap[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
  endtask

  // Output table per state, straight from the operation description.
  function automatic logic [17:0] expect_out(input int s, input bit m);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, ill;
    logic [1:0] pcs, asb;
    logic [2:0] aop;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, ill} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 3'b000;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = m; pcw = m; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 3'b010; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      12: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, pcs, asb, aop, ill};
  endfunction

  // Each instruction is a list of phases; FETCH, MEMRD and MEMWR repeat while MemReady is low.
  task automatic start_instr(input logic [5:0] o);
    cur_op = o;
    mq.delete();
    mq.push_back(0);
    mq.push_back(1);
    case (o)
      OP_RTYPE: begin mq.push_back(6); mq.push_back(7); end
      OP_LW:    begin mq.push_back(2); mq.push_back(3); mq.push_back(4); end
      OP_SW:    begin mq.push_back(2); mq.push_back(5); end
      OP_BEQ:   mq.push_back(8);
      OP_J:     mq.push_back(9);
      OP_ADDI:  begin mq.push_back(10); mq.push_back(11); end
      default:  mq.push_back(12);
    endcase
  endtask

  task automatic step(input bit m);
    int s;
    s  = mq[0];
    mr = m;
    op = (s == 1) ? cur_op : 6'($urandom);
    #1;
    chk("state", 32'(st), 32'(s));
    chk("outputs", 32'(a_vec), 32'(expect_out(s, m)));
    hist.push_back(int'(st));
    if (a_mwr) nmw++;
    if (a_rw) nrw++;
    if (a_m2r) begin
      nm2r++;
      if (st != 4'd4) m2r_bad++;
    end
    if (st < 4'd13) cap[st] = a_vec;
    cycles++;
    @(posedge clk);
    if (!((s == 0 || s == 3 || s == 5) && !m) && s != 12) void'(mq.pop_front());
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [5:0] o, input int mode);
    int guard;
    bit m;
    start_instr(o);
    hist.delete();
    cycles = 0; nmw = 0; nrw = 0; nm2r = 0; m2r_bad = 0; guard = 0;
    while (mq.size() > 0 && mq[0] != 12 && guard < 100) begin
      if (mode == 0) m = 1'b1;
      else if (mode == 1) m = ($urandom_range(0, 9) < 7);
      else if (mq[0] == 5 && stall_left > 0) begin m = 1'b0; stall_left--; end
      else m = 1'b1;
      step(m);
      guard++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mr  = 1'($urandom);
    #1;
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_outputs", 32'(a_vec), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  initial begin
    logic [5:0] rop;
    int guard;
    rst = 1'b1; mr = 1'b0; op = '0;
    b_rst = 1'b1; b_mr = 1'b1; b_op = '0;
    @(negedge clk);
    #1;
    chk("b_rst_state", 32'(b_st), 32'd0);
    chk("b_rst_outputs", 32'(b_vec), 32'd0);

    // Parameterised-off jump must trap and stay trapped until reset.
    b_rst = 1'b0; b_mr = 1'b1; b_op = OP_J;
    @(posedge clk); @(negedge clk);
    #1 chk("b_decode", 32'(b_st), 32'd1);
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      b_mr = 1'($urandom);
      b_op = 6'($urandom);
      #1;
      chk("b_trap_state", 32'(b_st), 32'd12);
      chk("b_trap_illegal", 32'(b_ill), 32'd1);
      chk("b_trap_quiet", 32'(b_vec[17:1]), 32'd0);
      @(negedge clk);
    end
    b_rst = 1'b1;
    #1;
    chk("b_clear_illegal", 32'(b_ill), 32'd0);
    chk("b_clear_state", 32'(b_st), 32'd0);
    @(negedge clk);
    b_rst = 1'b0; b_mr = 1'b1; b_op = OP_ADDI;
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1 chk("b_addi_trap", 32'(b_st), 32'd12);
    b_rst = 1'b1;

    do_reset();
    mr = 1'b1;
    #1 chk("first_fetch", 32'({a_mrd, a_irw, a_pcw}), 32'b111);

    run_instr(OP_LW, 0);
    chk("lw_len", 32'(hist.size()), 32'd5);
    chk("lw_s0", 32'(hist[0]), 32'd0);
    chk("lw_s1", 32'(hist[1]), 32'd1);
    chk("lw_s2", 32'(hist[2]), 32'd2);
    chk("lw_s3", 32'(hist[3]), 32'd3);
    chk("lw_s4", 32'(hist[4]), 32'd4);
    chk("lw_regwrite_cycles", 32'(nrw), 32'd1);
    chk("lw_memtoreg_cycles", 32'(nm2r), 32'd1);
    chk("lw_memtoreg_place", 32'(m2r_bad), 32'd0);
    #1 chk("lw_back_fetch", 32'(st), 32'd0);

    stall_left = 3;
    run_instr(OP_SW, 2);
    chk("sw_total_cycles", 32'(cycles), 32'd7);
    chk("sw_memwrite_cycles", 32'(nmw), 32'd4);

    run_instr(OP_BEQ, 0);
    chk("beq_cycles", 32'(cycles), 32'd3);
    chk("beq_pcwritecond", 32'(cap[8][16]), 32'd1);
    chk("beq_aluop", 32'(cap[8][3:1]), 32'b001);
    chk("beq_pcsource", 32'(cap[8][7:6]), 32'b01);

    run_instr(OP_RTYPE, 0);
    chk("r_cycles", 32'(cycles), 32'd4);
    chk("r_exec_aluop", 32'(cap[6][3:1]), 32'b010);
    chk("r_wb_regdst", 32'(cap[7][10]), 32'd1);
    chk("r_wb_regwrite", 32'(cap[7][9]), 32'd1);
    chk("r_regwrite_cycles", 32'(nrw), 32'd1);

    run_instr(OP_J, 0);
    chk("j_cycles", 32'(cycles), 32'd3);
    run_instr(OP_ADDI, 0);
    chk("addi_cycles", 32'(cycles), 32'd4);
    chk("addi_regwrite_cycles", 32'(nrw), 32'd1);

    // Abort in MEMWB: enables must drop while reset is high, before any edge.
    start_instr(OP_LW);
    guard = 0;
    while (mq[0] != 4 && guard < 20) begin step(1'b1); guard++; end
    chk("memwb_reach_bound", 32'(guard < 20), 32'd1);
    mr = 1'b1;
    #1 chk("memwb_regwrite", 32'(a_rw), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_regwrite", 32'(a_rw), 32'd0);
    chk("abort_state", 32'(st), 32'd0);
    chk("abort_outputs", 32'(a_vec), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0: rop = OP_RTYPE;
        1: rop = OP_LW;
        2: rop = OP_SW;
        3: rop = OP_BEQ;
        4: rop = OP_J;
        5: rop = OP_ADDI;
        6: rop = 6'b000101;
        default: rop = 6'($urandom);
      endcase
      run_instr(rop, 1);
      if (mq.size() > 0 && mq[0] == 12) begin
        for (int k = 0; k < 3; k++) step(1'($urandom));
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

Parametrised multicycle control unit for the Fase 2 MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles on shared memory and ALU resources. It stalls on a memory-ready handshake, and raises a sticky trap on unsupported opcodes. It sits between the instruction register (opcode field) and every datapath mux, enable and ALU-control input.

## Interface
- `HAS_JUMP`, default 1: when 1, `j` (000010) is decoded; when 0, it is illegal.
- `HAS_ADDI`, default 1: when 1, `addi` (001000) is decoded; when 0, it is illegal.
- `STATEW`, default 4: width of the `State` debug output.
- `clkFase`  in  1  single clock; all state changes on the rising edge.
- `rstFase`  in  1  asynchronous, active-high reset.
- `Opcode`  in  6  IR[31:26]; sampled only in DECODE.
- `MemReady`  in  1  memory handshake; the current access completes on the edge where it is 1.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemToReg`, `IRWrite`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath controls.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `ALUSrcB`  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp`  out  3  000 = add, 001 = sub, 010 = use funct (drives the existing ALU control).
- `State`  out  `STATEW`  current state encoding.
- `Illegal`  out  1  sticky trap flag.

## Operation
- Moore outputs decode from state only, except that `IRWrite` and `PCWrite` in FETCH are gated by `MemReady`. Every output not listed for a state is 0.
- FETCH (0): `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=add, `PCSource`=00, `IRWrite`=`PCWrite`=`MemReady`.
  - `MemReady`=0: stay in FETCH.
  - `MemReady`=1: go to DECODE.
- DECODE (1): `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=add. Next state by opcode:
  - R-type (000000) → EXEC
  - `lw` (100011) / `sw` (101011) → MEMADR
  - `beq` (000100) → BRANCH
  - `j` → JUMP (if `HAS_JUMP`)
  - `addi` → ADDIEX (if `HAS_ADDI`)
  - anything else → TRAP
- MEMADR (2): `ALUSrcA`=1, `ALUSrcB`=10, add. Next is MEMRD for `lw`, MEMWR for `sw`.
- MEMRD (3): `MemRead`=1, `IorD`=1. Wait for `MemReady`, then go to MEMWB.
- MEMWB (4): `RegWrite`=1, `MemToReg`=1, `RegDst`=0. Next is FETCH.
- MEMWR (5): `MemWrite`=1, `IorD`=1. Hold until `MemReady`, then go to FETCH.
- EXEC (6): `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=010. Next is RWB.
- RWB (7): `RegDst`=1, `RegWrite`=1, `MemToReg`=0. Next is FETCH.
- BRANCH (8): `ALUSrcA`=1, `ALUSrcB`=00, sub, `PCWriteCond`=1, `PCSource`=01. Next is FETCH.
- JUMP (9): `PCWrite`=1, `PCSource`=10. Next is FETCH.
- ADDIEX (10): `ALUSrcA`=1, `ALUSrcB`=10, add. Next is ADDIWB.
- ADDIWB (11): `RegDst`=0, `RegWrite`=1, `MemToReg`=0. Next is FETCH.
- TRAP (12): `Illegal`=1 and all enables 0. Stays in TRAP until reset.
- The opcode is decoded only in DECODE; changes to `Opcode` in other states are ignored.

## Timing
- Reset:
  - While `rstFase`=1, asynchronously: state=FETCH, `State`=0, `Illegal`=0, and every enable and select is forced to 0 (including `MemRead`, `ALUSrcB`, `IRWrite` and `PCWrite`).
  - First fetch is the first rising edge after release with `MemReady`=1.
- Latency with `MemReady` held at 1: R-type 4 cycles, `lw` 5, `sw` 4, `beq` 3, `j` 3, `addi` 4.
- Each cycle with `MemReady`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs hold constant during the wait.
- `MemReady` is ignored in every other state.
- Reset asserted mid-instruction aborts the instruction immediately with no further write enables, including in the same cycle.
- `MemWrite` and `MemRead` are never 1 simultaneously. `RegWrite` is 1 for exactly one cycle per R-type, `lw` or `addi` instruction.

## Structure
- Package `fase2_pkg` holds:
  - the state enum (4-bit encodings above)
  - opcode constants: `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`
  - `ALUOp` constants: `ALU_ADD`, `ALU_SUB`, `ALU_FUNCT`
  - `ALUSrcB` / `PCSource` select constants
- Single module with a state register, a next-state block and an output decoder. No sub-module is needed.
- `State` is the enum cast to `STATEW` bits.

## Test plan
- Reset → `State`=0, all outputs 0. Release with `MemReady`=1 → `MemRead`=1, `IRWrite`=1, `PCWrite`=1 in cycle 1.
- `lw` with `MemReady`=1 → state sequence 0,1,2,3,4,0; `RegWrite`=1 and `MemToReg`=1 only in state 4.
- `sw` with `MemReady` low for 3 cycles in MEMWR → `MemWrite` held for 4 cycles, then FETCH; total 7 cycles.
- `beq` → state 8 with `PCWriteCond`=1, `ALUOp`=001, `PCSource`=01; R-type → state 6 with `ALUOp`=010, then state 7 with `RegDst`=1, `RegWrite`=1.
- `HAS_JUMP`=0 with opcode 000010 → TRAP (12) and `Illegal`=1, held for 10 cycles; `rstFase` pulse → `Illegal`=0, FETCH.
- `rstFase` asserted asynchronously during MEMWB → `RegWrite` drops before the next edge and the state is 0.
